xmonitor: RTL and testbench
===========================

XMONITOR -- requirements
Module: xmonitor

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- CHNL_NUM, 4: number of monitored channels, 1..32.
- DATA_WIDTH, 32: width of each channel's data.
- CNT_WIDTH, 16: width of the per-channel error counter and the threshold.
- TS_WIDTH, 32: width of the timestamp counter.
- FATAL_EN, 0: 1 = $fatal on detection; 0 = $warning. Simulation only.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- rst_i, in, 1: asynchronous active-high reset.
- en_i, in, 1: global monitor enable.
- clr_i, in, 1: synchronous clear of all status.
- vld_i, in, CHNL_NUM: per-channel qualifier.
- dat_i, in, CHNL_NUM*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- thresh_i, in, CNT_WIDTH: interrupt threshold; 0 disables the interrupt.
- err_o, out, CHNL_NUM: sticky per-channel error flags.
- err_cnt_o, out, CHNL_NUM*CNT_WIDTH: per-channel error counts, same packing as dat_i.
- first_vld_o, out, 1: the first-error record is valid.
- first_chnl_o, out, max(1,$clog2(CHNL_NUM)): channel of the first error.
- first_ts_o, out, TS_WIDTH: timestamp of the first error.
- irq_o, out, 1: threshold interrupt.
- state_o, out, 2: monitor state.
REQ-003 One clock only; reset is asynchronous and active-high on rst_i.

Function
REQ-004 Detection: det[k] SHALL be 1 when en_i is 1 and either vld_i[k] is X/Z, or vld_i[k] is 1 and the reduction XOR of channel k's data is X/Z.
- When vld_i[k] is 0, X/Z data on channel k SHALL be ignored.
REQ-005 All outputs SHALL be registered; a detection sampled at edge N SHALL be visible on the outputs after edge N.
REQ-006 err_o[k] SHALL set on det[k] and hold until clr_i or reset.
REQ-007 err_cnt_o[k] SHALL increment by 1 per cycle in which det[k] is 1.
- The counter SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-008 The timestamp counter SHALL increment every cycle from 0 after reset, independent of en_i and clr_i.
- It SHALL wrap from all-ones to 0.
REQ-009 First-error capture: on the first cycle with any det bit set while first_vld_o=0, the block SHALL:
- load first_chnl_o with the lowest-indexed detecting channel;
- load first_ts_o with the current timestamp;
- set first_vld_o.
The record SHALL then freeze until clr_i.
REQ-010 irq_o SHALL be registered and equal 1 when thresh_i is non-zero and at least one post-update counter is greater than or equal to thresh_i.
- irq_o SHALL drop one cycle after thresh_i changes such that the condition no longer holds.
REQ-011 State machine, encoded in state_o:
- IDLE=0, ARMED=1, TRIPPED=2.
- IDLE goes to ARMED when en_i=1.
- ARMED goes to TRIPPED on any det.
- ARMED goes to IDLE when en_i=0.
- TRIPPED goes to IDLE only on clr_i; en_i=0 leaves TRIPPED unchanged.
REQ-012 clr_i SHALL take priority over detection in the same cycle.
- That cycle it SHALL zero err_o, all counters, first_vld_o, first_chnl_o, first_ts_o and irq_o.
- The state SHALL become IDLE, and that cycle's detections SHALL be dropped.
REQ-013 Simultaneous detections on several channels SHALL update every detecting channel's flag and counter in the same cycle.
REQ-014 On each detection (simulation only), the block SHALL print the channel index and timestamp, using $fatal when FATAL_EN=1 and $warning otherwise.
- The message code SHALL be excluded from synthesis via translate_off/on.

Reset
REQ-015 While rst_i is 1, the block SHALL immediately hold these values:
- err_o, err_cnt_o, first_vld_o, first_chnl_o, first_ts_o, irq_o and the timestamp at 0;
- state_o at IDLE.
REQ-016 Reset asserted mid-operation SHALL discard all captured status.
- No detection SHALL be recorded in the first edge after rst_i deasserts unless en_i is 1 at that edge.

Structure
REQ-017 A package xmonitor_pkg SHALL hold the state enum (IDLE/ARMED/TRIPPED) and the state-width constant.
REQ-018 A sub-module xmonitor_chnl SHALL implement one channel's detection, sticky flag and saturating counter.
- xmonitor SHALL instantiate it CHNL_NUM times via generate.
- The timestamp, first-error capture, irq and state machine SHALL stay in the top level.
REQ-019 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-020 CHNL_NUM=4, en_i=1, vld_i=4'b0100, channel 2 data bit 5 = X for 3 cycles -> err_o=4'b0100, count[2]=3, first_chnl_o=2, first_ts_o=timestamp at the first X cycle, state=TRIPPED.
REQ-021 vld_i=0 with X data on all channels for 10 cycles -> no flags set, counters 0, state ARMED.
REQ-022 Channels 1 and 3 X in the same cycle with thresh_i=2, for 2 cycles -> first_chnl_o=1, count[1]=count[3]=2, irq_o=1 after the 2nd edge.
REQ-023 CNT_WIDTH=4, 20 consecutive detections on channel 0 -> count[0] holds 15.
REQ-024 clr_i asserted in a cycle with an active X on channel 0 -> next cycle everything is 0, state=IDLE, and the detection is not counted.
REQ-025 rst_i pulsed asynchronously mid-cycle while TRIPPED -> all outputs 0 and state IDLE before the next clock edge.

Source files
------------

// File: rtl/xmonitor_pkg.sv
// Shared types for the X/Z monitor: state encoding and its width.
package xmonitor_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } state_e;

endpackage

// File: rtl/xmonitor_chnl.sv
// One monitored channel: X/Z detection, sticky error flag, saturating error count.
// Flag/count registered one edge after detection; no backpressure (pure observer).
module xmonitor_chnl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  det_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic [CNT_WIDTH-1:0]  cnt_nxt_o
);

  logic                 det;
  logic                 err_q;
  logic                 err_nxt;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  // An unknown qualifier is itself an error; data is only inspected when qualified.
  always_comb begin
    det = 1'b0;
    if (en_i) begin
      if ($isunknown(vld_i)) begin
        det = 1'b1;
      end else if (vld_i) begin
        det = $isunknown(^dat_i);
      end
    end
  end

  always_comb begin
    err_nxt = err_q;
    cnt_nxt = cnt_q;
    if (clr_i) begin
      err_nxt = 1'b0;
      cnt_nxt = '0;
    end else if (det) begin
      err_nxt = 1'b1;
      if (cnt_q != '1) begin
        cnt_nxt = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign det_o     = det;
  assign err_o     = err_q;
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_nxt;

endmodule

// File: rtl/xmonitor.sv
// X/Z monitor over CHNL_NUM qualified channels with first-error record, threshold irq and state.
// All outputs registered, one edge after the sampled detection; no backpressure.
module xmonitor
  import xmonitor_pkg::*;
#(
  parameter int CHNL_NUM   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TS_WIDTH   = 32,
  parameter int FATAL_EN   = 0,
  localparam int CHNL_W    = (CHNL_NUM > 1) ? $clog2(CHNL_NUM) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           clr_i,
  input  logic [CHNL_NUM-1:0]            vld_i,
  input  logic [CHNL_NUM*DATA_WIDTH-1:0] dat_i,
  input  logic [CNT_WIDTH-1:0]           thresh_i,
  output logic [CHNL_NUM-1:0]            err_o,
  output logic [CHNL_NUM*CNT_WIDTH-1:0]  err_cnt_o,
  output logic                           first_vld_o,
  output logic [CHNL_W-1:0]              first_chnl_o,
  output logic [TS_WIDTH-1:0]            first_ts_o,
  output logic                           irq_o,
  output logic [STATE_W-1:0]             state_o
);

  logic [CHNL_NUM-1:0]  det;
  logic [CNT_WIDTH-1:0] cnt_nxt [CHNL_NUM];
  logic                 any_det;
  logic [CHNL_W-1:0]    lo_idx;
  logic                 irq_hit;

  logic [TS_WIDTH-1:0]  ts_q;
  logic                 first_vld_q;
  logic [CHNL_W-1:0]    first_chnl_q;
  logic [TS_WIDTH-1:0]  first_ts_q;
  logic                 irq_q;
  state_e               state_q;
  state_e               state_nxt;

  for (genvar g = 0; g < CHNL_NUM; g++) begin : g_chnl
    xmonitor_chnl #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_chnl (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .clr_i     (clr_i),
      .vld_i     (vld_i[g]),
      .dat_i     (dat_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .det_o     (det[g]),
      .err_o     (err_o[g]),
      .cnt_o     (err_cnt_o[g*CNT_WIDTH +: CNT_WIDTH]),
      .cnt_nxt_o (cnt_nxt[g])
    );
  end

  assign any_det = |det;

  // Scan downwards so the lowest detecting channel wins.
  always_comb begin
    lo_idx = '0;
    for (int k = CHNL_NUM - 1; k >= 0; k--) begin
      if (det[k]) begin
        lo_idx = CHNL_W'(k);
      end
    end
  end

  // Compare against the post-update counts so irq tracks the flags it is registered with.
  always_comb begin
    irq_hit = 1'b0;
    for (int k = 0; k < CHNL_NUM; k++) begin
      if (cnt_nxt[k] >= thresh_i) begin
        irq_hit = 1'b1;
      end
    end
    if (thresh_i == '0 || clr_i) begin
      irq_hit = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (en_i) state_nxt = ARMED;
      ARMED:   begin
        if (any_det) begin
          state_nxt = TRIPPED;
        end else if (!en_i) begin
          state_nxt = IDLE;
        end
      end
      TRIPPED: state_nxt = TRIPPED;
      default: state_nxt = IDLE;
    endcase
    if (clr_i) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q         <= '0;
      first_vld_q  <= 1'b0;
      first_chnl_q <= '0;
      first_ts_q   <= '0;
      irq_q        <= 1'b0;
      state_q      <= IDLE;
    end else begin
      ts_q    <= ts_q + TS_WIDTH'(1);
      irq_q   <= irq_hit;
      state_q <= state_nxt;
      if (clr_i) begin
        first_vld_q  <= 1'b0;
        first_chnl_q <= '0;
        first_ts_q   <= '0;
      end else if (!first_vld_q && any_det) begin
        first_vld_q  <= 1'b1;
        first_chnl_q <= lo_idx;
        first_ts_q   <= ts_q;
      end
    end
  end

  assign first_vld_o  = first_vld_q;
  assign first_chnl_o = first_chnl_q;
  assign first_ts_o   = first_ts_q;
  assign irq_o        = irq_q;
  assign state_o      = state_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < CHNL_NUM; k++) begin
        if (det[k]) begin
          if (FATAL_EN != 0) begin
            $fatal(1, "xmonitor: X/Z on channel %0d at ts %0d", k, ts_q);
          end else begin
            $warning("xmonitor: X/Z on channel %0d at ts %0d", k, ts_q);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_xmonitor.sv
// Randomized bench for xmonitor against a behavioural model, plus literal scenario pins.
module tb_xmonitor;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int TW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            en_i;
  logic            clr_i;
  logic [N-1:0]    vld_i;
  logic [N*DW-1:0] dat_i;
  logic [CW-1:0]   thresh_i;
  logic [N-1:0]    err_o;
  logic [N*CW-1:0] err_cnt_o;
  logic            first_vld_o;
  logic [1:0]      first_chnl_o;
  logic [TW-1:0]   first_ts_o;
  logic            irq_o;
  logic [1:0]      state_o;

  xmonitor #(
    .CHNL_NUM   (N),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .TS_WIDTH   (TW),
    .FATAL_EN   (0)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .vld_i        (vld_i),
    .dat_i        (dat_i),
    .thresh_i     (thresh_i),
    .err_o        (err_o),
    .err_cnt_o    (err_cnt_o),
    .first_vld_o  (first_vld_o),
    .first_chnl_o (first_chnl_o),
    .first_ts_o   (first_ts_o),
    .irq_o        (irq_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  bit four_state;

  // Model state: plain integers, updated once per clock edge from the sampled inputs.
  int m_err [N];
  int m_cnt [N];
  int m_fv, m_fc, m_fts, m_irq, m_state, m_ts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_det(input int k);
    logic          v;
    logic [DW-1:0] d;
    v = vld_i[k];
    d = dat_i[k*DW +: DW];
    if (en_i !== 1'b1) return 1'b0;
    if ($isunknown(v)) return 1'b1;
    return (v === 1'b1) && $isunknown(d);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_err[k] = 0;
      m_cnt[k] = 0;
    end
    m_fv = 0; m_fc = 0; m_fts = 0; m_irq = 0; m_state = 0;
  endtask

  task automatic model_step();
    bit d [N];
    bit any;
    int lo;
    if (rst_i) begin
      model_clear();
      m_ts = 0;
      return;
    end
    any = 0;
    lo  = -1;
    for (int k = 0; k < N; k++) begin
      d[k] = m_det(k);
      if (d[k]) begin
        any = 1;
        if (lo < 0) lo = k;
      end
    end
    if (clr_i) begin
      model_clear();
    end else begin
      for (int k = 0; k < N; k++) begin
        if (d[k]) begin
          m_err[k] = 1;
          m_cnt[k] = (m_cnt[k] >= CMAX) ? CMAX : m_cnt[k] + 1;
        end
      end
      if (m_fv == 0 && any) begin
        m_fv = 1; m_fc = lo; m_fts = m_ts;
      end
      m_irq = 0;
      for (int k = 0; k < N; k++) begin
        if (thresh_i != 0 && m_cnt[k] >= int'(thresh_i)) m_irq = 1;
      end
      if (m_state == 0) begin
        if (en_i) m_state = 1;
      end else if (m_state == 1) begin
        if (any) m_state = 2;
        else if (!en_i) m_state = 0;
      end
    end
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic compare_all();
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = (m_err[k] != 0);
    check("err_o", 32'(err_o), 32'(e));
    for (int k = 0; k < N; k++) begin
      check($sformatf("err_cnt[%0d]", k), 32'(err_cnt_o[k*CW +: CW]), m_cnt[k]);
    end
    check("first_vld_o", 32'(first_vld_o), m_fv);
    check("first_chnl_o", 32'(first_chnl_o), m_fc);
    check("first_ts_o", 32'(first_ts_o), m_fts);
    check("irq_o", 32'(irq_o), m_irq);
    check("state_o", 32'(state_o), m_state);
  endtask

  always @(posedge clk_i) begin
    model_step();
    #2;
    compare_all();
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  function automatic logic [CW-1:0] cnt_of(input int k);
    return err_cnt_o[k*CW +: CW];
  endfunction

  initial begin
    logic probe;
    int   b;
    int   r;
    probe      = 1'bx;
    four_state = $isunknown(probe);
    rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0;
    vld_i = '0; dat_i = '0; thresh_i = '0;
    cyc(1);
    check("rst err_o", 32'(err_o), 0);
    check("rst err_cnt_o", 32'(err_cnt_o), 0);
    check("rst first_vld_o", 32'(first_vld_o), 0);
    check("rst state_o", 32'(state_o), 0);
    cyc(1);
    rst_i = 1'b0;

    // Enable one clean cycle (ts 0), then X on channel 2 bit 5 from ts 1 for 3 cycles.
    en_i = 1'b1;
    cyc(1);
    vld_i = 4'b0100;
    dat_i = $urandom;
    dat_i[2*DW+5] = 1'bx;
    cyc(3);
    vld_i = '0; dat_i = '0;
    if (four_state) begin
      check("s1 err_o", 32'(err_o), 32'b0100);
      check("s1 cnt2", 32'(cnt_of(2)), 3);
      check("s1 first_chnl", 32'(first_chnl_o), 2);
      check("s1 first_ts", 32'(first_ts_o), 1);
      check("s1 state", 32'(state_o), 2);
    end

    // Unqualified X data is ignored.
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    dat_i = 'x;
    cyc(10);
    dat_i = '0;
    check("s2 err_o", 32'(err_o), 0);
    check("s2 err_cnt_o", 32'(err_cnt_o), 0);
    check("s2 first_vld", 32'(first_vld_o), 0);
    check("s2 state", 32'(state_o), 1);

    // Channels 1 and 3 together, threshold 2.
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    thresh_i = 2;
    cyc(1);
    vld_i = 4'b1010;
    dat_i = $urandom;
    dat_i[1*DW+0] = 1'bx;
    dat_i[3*DW+7] = 1'bz;
    cyc(1);
    if (four_state) check("s3 irq after 1", 32'(irq_o), 0);
    cyc(1);
    vld_i = '0; dat_i = '0;
    if (four_state) begin
      check("s3 first_chnl", 32'(first_chnl_o), 1);
      check("s3 cnt1", 32'(cnt_of(1)), 2);
      check("s3 cnt3", 32'(cnt_of(3)), 2);
      check("s3 irq after 2", 32'(irq_o), 1);
    end
    thresh_i = 3;
    cyc(1);
    check("s3 irq drop", 32'(irq_o), 0);

    // Saturation: 20 detections on a 4-bit counter.
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    thresh_i = 0;
    vld_i = 4'b0001;
    dat_i = '0;
    dat_i[3] = 1'bx;
    cyc(20);
    if (four_state) check("s4 cnt0 sat", 32'(cnt_of(0)), 15);

    // Clear wins over a live detection.
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    vld_i = '0; dat_i = '0;
    check("s5 err_o", 32'(err_o), 0);
    check("s5 err_cnt_o", 32'(err_cnt_o), 0);
    check("s5 first_vld", 32'(first_vld_o), 0);
    check("s5 first_ts", 32'(first_ts_o), 0);
    check("s5 irq", 32'(irq_o), 0);
    check("s5 state", 32'(state_o), 0);

    for (int i = 0; i < 700; i++) begin
      en_i  = ($urandom_range(0, 9) != 0);
      clr_i = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) thresh_i = CW'($urandom);
      vld_i = N'($urandom);
      dat_i = $urandom;
      for (int k = 0; k < N; k++) begin
        r = $urandom_range(0, 19);
        b = $urandom_range(0, DW - 1);
        if (r == 0) vld_i[k] = 1'bx;
        else if (r < 3) dat_i[k*DW + b] = 1'bx;
        else if (r == 3) dat_i[k*DW + b] = 1'bz;
      end
      cyc(1);
    end

    // Asynchronous reset mid-cycle while tripped.
    clr_i = 1'b1; en_i = 1'b1; vld_i = '0; dat_i = '0;
    cyc(1);
    clr_i = 1'b0; thresh_i = 1;
    cyc(1);
    vld_i = 4'b0001;
    dat_i[0] = 1'bx;
    cyc(2);
    if (four_state) check("s6 state before rst", 32'(state_o), 2);
    #2;
    rst_i = 1'b1;
    #1;
    check("s6 err_o", 32'(err_o), 0);
    check("s6 err_cnt_o", 32'(err_cnt_o), 0);
    check("s6 first_vld", 32'(first_vld_o), 0);
    check("s6 first_chnl", 32'(first_chnl_o), 0);
    check("s6 first_ts", 32'(first_ts_o), 0);
    check("s6 irq", 32'(irq_o), 0);
    check("s6 state", 32'(state_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0; en_i = 1'b0; vld_i = 'x;
    cyc(1);
    check("s7 err_o disabled", 32'(err_o), 0);
    check("s7 state disabled", 32'(state_o), 0);
    vld_i = '0; dat_i = '0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
